// File: rtl/ssio_sdr_out_gated_if.sv
// Valid/ready word stream into the gated-clock SDR transmitter.
interface ssio_sdr_out_gated_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/ssio_sdr_out_gated.sv
// Source-synchronous SDR transmitter with a forwarded clock that only
// runs for the duration of a burst (preamble, words, gap, postamble).
module oddr #(
  parameter string TARGET      = "GENERIC",
  parameter string IODDR_STYLE = "IODDR2",
  parameter int    WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q
);
  localparam bit VALID_CFG =
    (TARGET == "SIM" || TARGET == "GENERIC" ||
     TARGET == "XILINX" || TARGET == "ALTERA") &&
    (IODDR_STYLE == "IODDR" || IODDR_STYLE == "IODDR2");

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d2;
  logic [WIDTH-1:0] w_q;

  // Exactly one register changes per edge, so the XOR output is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p  <= '0;
      r_d2 <= '0;
    end else begin
      r_p  <= d1 ^ r_n;
      r_d2 <= d2;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_n <= '0;
    end else begin
      r_n <= r_d2 ^ r_p;
    end
  end

  assign w_q = r_p ^ r_n;
  assign q   = VALID_CFG ? w_q : '0;
endmodule

module ssio_sdr_out_gated #(
  parameter string            TARGET           = "GENERIC",
  parameter string            IODDR_STYLE      = "IODDR2",
  parameter int               WIDTH            = 8,
  parameter int               PREAMBLE_CYCLES  = 2,
  parameter int               POSTAMBLE_CYCLES = 2,
  parameter int               GAP_LIMIT        = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE       = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ssio_sdr_out_gated_if.slave  s,
  output logic                 output_clk,
  output logic [WIDTH-1:0]     output_q,
  output logic                 status_busy,
  output logic                 status_underrun
);
  localparam int M1   = (PREAMBLE_CYCLES > POSTAMBLE_CYCLES) ?
                        PREAMBLE_CYCLES : POSTAMBLE_CYCLES;
  localparam int MAXC = (M1 > GAP_LIMIT) ? M1 : GAP_LIMIT;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PRE_INIT =
    CW'(PREAMBLE_CYCLES > 0 ? PREAMBLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] POST_INIT =
    CW'(POSTAMBLE_CYCLES > 0 ? POSTAMBLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACTIVE,
    ST_POST
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_ready;
  logic             r_busy;
  logic             r_underrun;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_underrun_nxt;
  logic             w_accept;
  logic [CW-1:0]    w_gap;
  logic             w_run;
  logic             w_oclk;

  assign w_accept = s.valid & r_ready;
  assign w_gap    = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_q_nxt        = IDLE_VALUE;
    w_underrun_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s.valid) begin
          if (PREAMBLE_CYCLES == 0) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_PRE;
            w_cnt_nxt   = PRE_INIT;
          end
        end
      end
      ST_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_ACTIVE: begin
        // cnt doubles as the consecutive-gap counter here
        if (w_accept) begin
          w_q_nxt   = s.data;
          w_cnt_nxt = '0;
        end else begin
          w_underrun_nxt = 1'b1;
          if (w_gap == GAP_END) begin
            if (POSTAMBLE_CYCLES == 0) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_POST;
              w_cnt_nxt   = POST_INIT;
            end
          end else begin
            w_cnt_nxt = w_gap;
          end
        end
      end
      ST_POST: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_q        <= IDLE_VALUE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_q        <= w_q_nxt;
      r_ready    <= (w_state_nxt == ST_ACTIVE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_underrun <= w_underrun_nxt;
    end
  end

  // Run flag goes through the oddr register so each clock high phase
  // lands mid-cycle of the output_q word produced in the same state.
  assign w_run = (r_state != ST_IDLE);

  oddr #(
    .TARGET      (TARGET),
    .IODDR_STYLE (IODDR_STYLE),
    .WIDTH       (1)
  ) u_oddr (
    .clk (clk),
    .rst (rst),
    .d1  (1'b0),
    .d2  (w_run),
    .q   (w_oclk)
  );

  assign s.ready         = r_ready;
  assign output_clk      = w_oclk;
  assign output_q        = r_q;
  assign status_busy     = r_busy;
  assign status_underrun = r_underrun;
endmodule

// File: tb/tb_ssio_sdr_out_gated.sv
// Bench for ssio_sdr_out_gated: pin-stream model per burst, checked
// on every forwarded-clock rising edge, plus literal expectations.
module tb_ssio_sdr_out_gated;
  localparam logic [7:0] IDL = 8'h00;

  typedef struct packed {
    logic [7:0] q;
    logic       ur;
  } pin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssio_sdr_out_gated_if #(.WIDTH(8)) ifa ();
  ssio_sdr_out_gated_if #(.WIDTH(8)) ifb ();

  logic       oclk0, oclk1;
  logic [7:0] oq0, oq1;
  logic       busy0, busy1;
  logic       ur0, ur1;

  ssio_sdr_out_gated #(.WIDTH(8)) u0 (
    .clk             (clk),
    .rst             (rst),
    .s               (ifa),
    .output_clk      (oclk0),
    .output_q        (oq0),
    .status_busy     (busy0),
    .status_underrun (ur0)
  );

  ssio_sdr_out_gated #(
    .WIDTH            (8),
    .PREAMBLE_CYCLES  (0),
    .POSTAMBLE_CYCLES (0),
    .GAP_LIMIT        (1)
  ) u1 (
    .clk             (clk),
    .rst             (rst),
    .s               (ifb),
    .output_clk      (oclk1),
    .output_q        (oq1),
    .status_busy     (busy1),
    .status_underrun (ur1)
  );

  int n_vec = 0;
  int n_err = 0;
  int edges0 = 0;
  int edges1 = 0;
  pin_t exp0[$];
  pin_t exp1[$];
  logic [7:0] log0[$];
  logic [7:0] log1[$];
  logic [7:0] ws[$];
  logic [7:0] lit[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic model_burst(input int which, input logic [7:0] w[$],
                             input int gap_after, input int pre,
                             input int gl, input int post);
    pin_t s[$];
    pin_t p;
    for (int i = 0; i < pre; i++) begin
      p.q = IDL; p.ur = 1'b0; s.push_back(p);
    end
    foreach (w[i]) begin
      p.q = w[i]; p.ur = 1'b0; s.push_back(p);
      if (i == gap_after) begin
        p.q = IDL; p.ur = 1'b1; s.push_back(p);
      end
    end
    for (int i = 0; i < gl; i++) begin
      p.q = IDL; p.ur = 1'b1; s.push_back(p);
    end
    for (int i = 0; i < post; i++) begin
      p.q = IDL; p.ur = 1'b0; s.push_back(p);
    end
    foreach (s[i]) begin
      if (which == 0) exp0.push_back(s[i]);
      else exp1.push_back(s[i]);
    end
  endtask

  task automatic expect0(input logic [7:0] q, input logic ur);
    pin_t p;
    p.q = q; p.ur = ur;
    exp0.push_back(p);
  endtask

  always @(posedge oclk0) begin
    #1;
    edges0++;
    log0.push_back(oq0);
    if (exp0.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL u0_extra_edge: got clock edge with q=%0h, required none", oq0);
    end else begin
      pin_t e;
      e = exp0.pop_front();
      check("u0_q", oq0, e.q);
      check("u0_underrun", ur0, e.ur);
    end
  end

  always @(posedge oclk1) begin
    #1;
    edges1++;
    log1.push_back(oq1);
    if (exp1.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL u1_extra_edge: got clock edge with q=%0h, required none", oq1);
    end else begin
      pin_t e;
      e = exp1.pop_front();
      check("u1_q", oq1, e.q);
      check("u1_underrun", ur1, e.ur);
    end
  end

  task automatic push0(input logic [7:0] d);
    int t;
    t = 0;
    ifa.data = d;
    ifa.valid = 1'b1;
    @(negedge clk);
    while (!ifa.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifa.ready) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: s_ready got 0, required 1 for word %0h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0;
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (busy0 && t < 200);
    if (busy0) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: status_busy got 1, required 0");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic new_test;
    edges0 = 0;
    edges1 = 0;
    log0.delete();
    log1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    ifa.data = 8'h00; ifa.valid = 1'b0;
    ifb.data = 8'h00; ifb.valid = 1'b0;

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_clk", oclk0, 0);
    check("rst_q", oq0, IDL);
    check("rst_ready", ifa.ready, 0);
    check("rst_busy", busy0, 0);
    check("rst_underrun", ur0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_clk", oclk0, 0);
      check("idle_q", oq0, IDL);
      check("idle_ready", ifa.ready, 0);
      check("idle_busy", busy0, 0);
    end
    @(posedge clk);
    #1;

    // default burst 11..15
    new_test();
    ws = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    model_burst(0, ws, -1, 2, 4, 2);
    foreach (ws[i]) push0(ws[i]);
    ifa.valid = 1'b0;
    wait_idle0();
    check("t2_edges", edges0, 13);
    check("t2_left", exp0.size(), 0);
    lit = {8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check("t2_log_len", log0.size(), 13);
    if (log0.size() == 13) begin
      for (int i = 0; i < 13; i++) check("t2_pin", log0[i], lit[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t2_clk_held", oclk0, 0);
    end

    // one-cycle valid gap between 0x12 and 0x13
    new_test();
    model_burst(0, ws, 1, 2, 4, 2);
    push0(8'h11);
    push0(8'h12);
    ifa.valid = 1'b0;
    @(posedge clk);
    #1;
    push0(8'h13);
    push0(8'h14);
    push0(8'h15);
    ifa.valid = 1'b0;
    wait_idle0();
    check("t3_edges", edges0, 14);
    check("t3_left", exp0.size(), 0);
    if (log0.size() > 4) check("t3_gap_word", log0[4], IDL);

    // no preamble/postamble, gap limit 1, single word
    new_test();
    ws = {8'hA5};
    model_burst(1, ws, -1, 0, 1, 0);
    ifb.data = 8'hA5;
    ifb.valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ifb.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t4_ready", ifb.ready, 1);
    @(posedge clk);
    #1;
    ifb.valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t4_edges", edges1, 2);
    check("t4_left", exp1.size(), 0);
    if (log1.size() > 0) check("t4_first", log1[0], 8'hA5);

    // valid re-asserted during POST
    new_test();
    ws = {8'h41, 8'h42, 8'h43};
    model_burst(0, ws, -1, 2, 4, 2);
    ws = {8'h51, 8'h52};
    model_burst(0, ws, -1, 2, 4, 2);
    push0(8'h41);
    push0(8'h42);
    push0(8'h43);
    ifa.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_in_post_ready", ifa.ready, 0);
    check("t5_in_post_busy", busy0, 1);
    push0(8'h51);
    push0(8'h52);
    ifa.valid = 1'b0;
    wait_idle0();
    check("t5_edges", edges0, 21);
    check("t5_left", exp0.size(), 0);

    // reset pulsed mid-ACTIVE
    new_test();
    expect0(IDL, 1'b0);
    expect0(IDL, 1'b0);
    expect0(8'h21, 1'b0);
    expect0(8'h22, 1'b0);
    push0(8'h21);
    push0(8'h22);
    @(negedge clk);
    #2;
    check("t6_clk_running", oclk0, 1);
    rst = 1'b1;
    #1;
    ifa.valid = 1'b0;
    check("t6_rst_clk", oclk0, 0);
    check("t6_rst_q", oq0, IDL);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_ready", ifa.ready, 0);
    check("t6_pre_left", exp0.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    new_test();
    ws = {8'h31, 8'h32};
    model_burst(0, ws, -1, 2, 4, 2);
    push0(8'h31);
    push0(8'h32);
    ifa.valid = 1'b0;
    wait_idle0();
    check("t6_edges", edges0, 10);
    check("t6_left", exp0.size(), 0);
    if (log0.size() > 2) begin
      check("t6_pre0", log0[0], IDL);
      check("t6_pre1", log0[1], IDL);
      check("t6_word0", log0[2], 8'h31);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
